imem_loader: RTL and testbench
==============================

# imem_loader

Instruction encoder and loader for the single-cycle MIPS datapath; the writing end of the instruction-memory path whose words the control unit decodes.
- Accepts one symbolic instruction per valid/ready handshake (operation select plus fields) and packs it into a 32-bit MIPS word.
- Writes each word to sequential instruction-memory addresses from 0, keeps a count and an XOR checksum, and stops on a last flag or when memory is full.
- Used by benches and boot logic to place programs before the CPU is released from reset.

## Interface
- ADDR_W, 6, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction request present.
- in_ready  out  1  loader can accept; equals (state == IDLE).
- in_op  in  3  0 R-type, 1 beq, 2 lw, 3 addi, 4 slti, 5 andi, 6 ori, 7 j.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register / shift fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  I-type immediate (raw bits, no extension).
- in_target  in  26  jump target field.
- in_last  in  1  marks final instruction of program.
- restart  in  1  leaves DONE, clears pointer/count/checksum.
- mem_we  out  1  registered write strobe, one cycle per word.
- mem_addr  out  ADDR_W  registered word address.
- mem_wdata  out  32  registered encoded instruction.
- count  out  ADDR_W+1  words written since reset/restart.
- csum  out  32  XOR of all words written since reset/restart.
- done  out  1  high in DONE state.

## Operation
- Encoding, by in_op:
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}.
  - I-type: {opcode, rs, rt, imm}, with beq 000100, lw 100011, addi 001000, slti 001010, andi 001100, ori 001101. rd, shamt and funct are ignored.
  - j: {6'b000010, target}. All other fields are ignored.
- Every in_op value is legal. There is no error output.
- FSM states: IDLE, WRITE, DONE.
- IDLE: in_ready=1. On in_valid at a rising edge:
  - mem_we<=1, mem_addr<=ptr, mem_wdata<=encoded word.
  - Latch in_last, go to WRITE.
- WRITE: in_ready=0. At the next edge:
  - mem_we<=0, ptr<=ptr+1, count<=count+1, csum<=csum^mem_wdata.
  - Go to DONE if the latched last flag is set or ptr==DEPTH-1; else go to IDLE.
- DONE: in_ready=0, done=1, in_valid ignored, no writes. restart at an edge: ptr, count, csum <=0, go to IDLE.
- restart is ignored in IDLE and WRITE.
- Reset: state IDLE, ptr 0, count 0, csum 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0.

## Timing
- Accept at edge N: mem_we/mem_addr/mem_wdata valid during cycle N+1. count/csum update at edge N+1, in_ready back high in cycle N+1 only if the next state is IDLE.
- Throughput: one word per 2 cycles; in_ready low during the WRITE cycle.
- Request fields are sampled only at the accepting edge. They may change after acceptance.
- Full boundary: the write to address DEPTH-1 always ends in DONE with count=DEPTH, regardless of in_last. The pointer never wraps.
- in_last on the write to DEPTH-1: DONE, same as the full case.
- Reset asserted during WRITE:
  - The strobe already presented in that cycle is not retracted; memory may capture it.
  - The block returns to reset values at that edge. count and csum do not include the word.
- Reset wins over restart and in_valid at the same edge.
- restart and in_valid together in DONE: restart taken, request not accepted (in_ready=0 that cycle).
- done asserts in the cycle after the final WRITE cycle and holds until restart or reset.

## Test plan
- R-type add $3,$1,$2 (op0, rs1, rt2, rd3, shamt0, funct 0x20) after reset:
  - mem_we=1 one cycle with addr 0, wdata 0x00221820.
  - count=1, csum=0x00221820.
- lw $8,4($9) (op2, rs9, rt8, imm 0x0004) then j 0x0000010 (op7) with in_last:
  - Words 0x8D280004 @1 and 0x08000010 @2 (after case 1).
  - done=1, count=3, further in_valid ignored.
- beq $1,$2,-1 (op1, imm 0xFFFF) with garbage rd/funct:
  - wdata 0x1022FFFF.
  - in_ready low exactly one cycle after acceptance.
- ADDR_W=2, continuous in_valid, no in_last:
  - Four writes at addr 0..3, then done=1, count=4, no fifth mem_we.
- In DONE, pulse restart together with in_valid:
  - No accept that cycle; count=0, csum=0.
  - Next accepted word written to addr 0.
- Assert reset during the WRITE cycle of the second word:
  - All outputs at reset values next cycle, count=0, in_ready=1.
  - The next word goes to addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction encoder and loader: packs one symbolic MIPS instruction per handshake
// into a 32-bit word and writes it to sequential instruction-memory addresses.
module imem_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              in_last,
   input  logic              restart,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic [31:0]       csum,
   output logic              done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [2:0] OP_R    = 3'd0;
   localparam logic [2:0] OP_BEQ  = 3'd1;
   localparam logic [2:0] OP_LW   = 3'd2;
   localparam logic [2:0] OP_ADDI = 3'd3;
   localparam logic [2:0] OP_SLTI = 3'd4;
   localparam logic [2:0] OP_ANDI = 3'd5;
   localparam logic [2:0] OP_ORI  = 3'd6;
   localparam logic [2:0] OP_J    = 3'd7;

   localparam logic [ADDR_W-1:0] PTR_LAST = '1;

   logic [1:0]        state_q,     state_d;
   logic [ADDR_W-1:0] ptr_q,       ptr_d;
   logic [ADDR_W:0]   count_q,     count_d;
   logic [31:0]       csum_q,      csum_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              last_q,      last_d;
   logic [31:0]       enc_word;

   // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      enc_word = 32'h0;
      case (in_op)
         OP_R:    enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
         OP_BEQ:  enc_word = {6'b000100, in_rs, in_rt, in_imm};
         OP_LW:   enc_word = {6'b100011, in_rs, in_rt, in_imm};
         OP_ADDI: enc_word = {6'b001000, in_rs, in_rt, in_imm};
         OP_SLTI: enc_word = {6'b001010, in_rs, in_rt, in_imm};
         OP_ANDI: enc_word = {6'b001100, in_rs, in_rt, in_imm};
         OP_ORI:  enc_word = {6'b001101, in_rs, in_rt, in_imm};
         OP_J:    enc_word = {6'b000010, in_target};
         default: enc_word = 32'h0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      count_d     = count_q;
      csum_d      = csum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      last_d      = last_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = ptr_q;
               mem_wdata_d = enc_word;
               last_d      = in_last;
               state_d     = S_WRITE;
            end
         end
         S_WRITE: begin
            count_d = count_q + 1'b1;
            csum_d  = csum_q ^ mem_wdata_q;
            // Pointer saturates at the last word; only restart or reset brings it back to 0.
            if (ptr_q != PTR_LAST) ptr_d = ptr_q + 1'b1;
            if (last_q || (ptr_q == PTR_LAST)) state_d = S_DONE;
            else                               state_d = S_IDLE;
         end
         S_DONE: begin
            if (restart) begin
               ptr_d   = '0;
               count_d = '0;
               csum_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         count_q     <= '0;
         csum_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         count_q     <= count_d;
         csum_q      <= csum_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         last_q      <= last_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign done      = (state_q == S_DONE);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign count     = count_q;
   assign csum      = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a default-size instance for the protocol cases
// and a 4-word instance for the memory-full boundary.
module tb_imem_loader;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        in_valid, in_ready, in_last, restart;
   logic [2:0]  in_op;
   logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
   logic [5:0]  in_funct;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        mem_we, done;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata, csum;
   logic [6:0]  count;

   logic        b_valid, b_ready, b_we, b_done, b_restart, b_last;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata, b_csum;
   logic [2:0]  b_count;

   imem_loader #(.ADDR_W(6)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
      .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .csum(csum), .done(done)
   );

   imem_loader #(.ADDR_W(2)) dut_small (
      .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
      .in_op(3'd6), .in_rs(5'd4), .in_rt(5'd4), .in_rd(5'd0), .in_shamt(5'd0),
      .in_funct(6'd0), .in_imm(16'h1234), .in_target(26'd0), .in_last(b_last),
      .restart(b_restart), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
      .count(b_count), .csum(b_csum), .done(b_done)
   );

   int n_tests = 0;
   int n_fail  = 0;
   wr_t sb_q[$];
   wr_t sb_small_q[$];
   logic [5:0]  exp_ptr;
   logic [6:0]  exp_count;
   logic [31:0] exp_csum;
   logic [31:0] pend_word;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (sb_q.size() == 0) check("unexpected_we", 1, 0);
         else begin
            wr_t e;
            e = sb_q.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(e.addr));
            check("wr_data", 64'(mem_wdata), 64'(e.data));
         end
      end
      if (b_we === 1'b1) begin
         if (sb_small_q.size() == 0) check("small_unexpected_we", 1, 0);
         else begin
            wr_t e;
            e = sb_small_q.pop_front();
            check("small_wr_addr", 64'(b_addr), 64'(e.addr));
            check("small_wr_data", 64'(b_wdata), 64'(e.data));
         end
      end
   end

   task automatic wait_ready();
      int k = 0;
      while (in_ready !== 1'b1 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (in_ready !== 1'b1) check("ready_timeout", 0, 1);
   endtask

   // Present a request, let it be accepted, then scramble the fields during WRITE.
   task automatic send_start(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                             input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                             input logic [31:0] exp_word);
      wr_t e;
      wait_ready();
      in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
      in_funct = fn; in_imm = imm; in_target = tgt; in_last = last;
      in_valid = 1'b1;
      e.addr = exp_ptr;
      e.data = exp_word;
      sb_q.push_back(e);
      pend_word = exp_word;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_op = 3'($urandom); in_rs = 5'($urandom); in_rt = 5'($urandom);
      in_imm = 16'($urandom); in_target = 26'($urandom); in_last = 1'($urandom);
      check("ready_low_in_write", 64'(in_ready), 0);
   endtask

   task automatic send_finish();
      @(posedge clk); #1;
      exp_ptr   = exp_ptr + 1'b1;
      exp_count = exp_count + 1'b1;
      exp_csum  = exp_csum ^ pend_word;
   endtask

   task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                       input logic [31:0] exp_word);
      send_start(op, rs, rt, rd, sh, fn, imm, tgt, last, exp_word);
      send_finish();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_we"},    64'(mem_we), 0);
      check({tag, "_addr"},  64'(mem_addr), 0);
      check({tag, "_wdata"}, 64'(mem_wdata), 0);
      check({tag, "_count"}, 64'(count), 0);
      check({tag, "_csum"},  64'(csum), 0);
      check({tag, "_done"},  64'(done), 0);
      check({tag, "_ready"}, 64'(in_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; restart = 1'b0;
      in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
      in_funct = '0; in_imm = '0; in_target = '0;
      b_valid = 1'b0; b_restart = 1'b0; b_last = 1'b0;
      exp_ptr = '0; exp_count = '0; exp_csum = '0; pend_word = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset = 1'b0;

      // add $3,$1,$2
      send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0, 32'h00221820);
      check("add_count", 64'(count), 1);
      check("add_csum", 64'(csum), 64'h00221820);
      check("add_ready", 64'(in_ready), 1);

      // lw $8,4($9) then j 0x10 marked last
      send(3'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b0, 32'h8D280004);
      send(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010, 1'b1, 32'h08000010);
      check("last_done", 64'(done), 1);
      check("last_count", 64'(count), 64'(exp_count));
      check("last_count_3", 64'(count), 3);
      check("last_csum", 64'(csum), 64'(exp_csum));
      check("last_ready", 64'(in_ready), 0);

      in_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("done_hold_count", 64'(count), 3);
      check("done_hold", 64'(done), 1);

      // restart together with in_valid: restart wins, nothing accepted
      restart = 1'b1; in_valid = 1'b1; in_op = 3'd3;
      check("restart_ready", 64'(in_ready), 0);
      @(posedge clk); #1;
      restart = 1'b0; in_valid = 1'b0;
      exp_ptr = '0; exp_count = '0; exp_csum = '0;
      check("restart_count", 64'(count), 0);
      check("restart_csum", 64'(csum), 0);
      check("restart_done", 64'(done), 0);
      check("restart_ready_back", 64'(in_ready), 1);
      check("restart_no_we", 64'(mem_we), 0);

      // beq $1,$2,-1 with garbage rd/shamt/funct/target
      send(3'd1, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h1022FFFF);
      check("beq_ready_one_cycle", 64'(in_ready), 1);
      check("beq_count", 64'(count), 1);

      // reset during the WRITE cycle of the second word
      send_start(3'd3, 5'd0, 5'd5, 5'd0, 5'd0, 6'h0, 16'h0007, 26'h0, 1'b0, 32'h20050007);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_ptr = '0; exp_count = '0; exp_csum = '0;
      check_reset_values("wr_reset");

      send(3'd6, 5'd4, 5'd4, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b0, 32'h34841234);
      send(3'd5, 5'd3, 5'd2, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'h0, 1'b0, 32'h306200FF);
      send(3'd4, 5'd7, 5'd6, 5'd0, 5'd0, 6'h0, 16'hFFFE, 26'h0, 1'b0, 32'h28E6FFFE);
      check("post_reset_count", 64'(count), 3);
      check("post_reset_csum", 64'(csum), 64'(exp_csum));
      check("main_sb_empty", 64'(sb_q.size()), 0);

      // 4-word memory: continuous requests, no last flag
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_t e;
         e.addr = 6'(i);
         e.data = 32'h34841234;
         sb_small_q.push_back(e);
      end
      b_valid = 1'b1;
      repeat (14) @(posedge clk);
      #1;
      check("full_done", 64'(b_done), 1);
      check("full_count", 64'(b_count), 4);
      check("full_csum", 64'(b_csum), 0);
      check("full_ready", 64'(b_ready), 0);
      check("full_all_written", 64'(sb_small_q.size()), 0);
      b_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
